// File: rtl/mcu51_pkg.sv
// Shared 8051-family constants: interrupt source indices, vector addresses
// and the interrupt controller state encoding.
package mcu51_pkg;

    localparam int NUM_SRC = 5;

    // Index order doubles as the fixed in-level priority (0 = highest)
    typedef enum logic [2:0] {
        SRC_IE0 = 3'd0,
        SRC_TF0 = 3'd1,
        SRC_IE1 = 3'd2,
        SRC_TF1 = 3'd3,
        SRC_SER = 3'd4
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_VECT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic [15:0] VEC_IE0 = 16'h0003;
    localparam logic [15:0] VEC_TF0 = 16'h000B;
    localparam logic [15:0] VEC_IE1 = 16'h0013;
    localparam logic [15:0] VEC_TF1 = 16'h001B;
    localparam logic [15:0] VEC_SER = 16'h0023;

    function automatic logic [15:0] src_vector(input src_e s);
        logic [15:0] v;
        case (s)
            SRC_IE0: v = VEC_IE0;
            SRC_TF0: v = VEC_TF0;
            SRC_IE1: v = VEC_IE1;
            SRC_TF1: v = VEC_TF1;
            SRC_SER: v = VEC_SER;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Two-flop synchronizer for an active-low external interrupt pin plus a
// falling-edge detector on the synchronized level.
module int_sync_edge (
    input  logic CLK,
    input  logic reset,
    input  logic pin,
    output logic sync,
    output logic fall
);

    logic meta;
    logic prev;

    // Preset high so an idle (high) pin never looks like a falling edge
    always_ff @(posedge CLK) begin
        if (!reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign fall = prev & ~sync;

endmodule

// File: rtl/int_ctrl.sv
// 8051-style two-level interrupt controller: flag capture, priority
// resolution, in-service tracking and the CPU request/ack handshake.
import mcu51_pkg::*;

module int_ctrl (
    input  logic        CLK,
    input  logic        reset,
    input  logic [7:0]  ie,
    input  logic [4:0]  ip,
    input  logic        int0_n,
    input  logic        int1_n,
    input  logic        it0,
    input  logic        it1,
    input  logic        tf0,
    input  logic        tf1,
    input  logic        ri,
    input  logic        ti,
    input  logic        ack,
    input  logic        reti,
    output logic        irq,
    output logic [15:0] vector,
    output logic        ie0,
    output logic        ie1,
    output logic        clr_tf0,
    output logic        clr_tf1,
    output logic        isr_hi,
    output logic        isr_lo
);

    logic sync0, sync1, fall0, fall1;
    logic flag0, flag1;

    int_sync_edge u_sync0 (.CLK(CLK), .reset(reset), .pin(int0_n), .sync(sync0), .fall(fall0));
    int_sync_edge u_sync1 (.CLK(CLK), .reset(reset), .pin(int1_n), .sync(sync1), .fall(fall1));

    state_e state, state_nx;
    src_e   cur_src, cur_src_nx, win_src;
    logic   cur_hi, cur_hi_nx, win_hi, win_any;
    logic   irq_nx, clr_tf0_nx, clr_tf1_nx;
    logic   [15:0] vector_nx;
    logic   set_hi, set_lo, drop_hi, drop_lo, clr_ie0, clr_ie1, reti_ok;
    logic   [NUM_SRC-1:0] flags, pend, hi_ok, lo_ok;

    // Level mode follows the pin directly; edge mode latches until serviced
    assign ie0 = it0 ? flag0 : ~sync0;
    assign ie1 = it1 ? flag1 : ~sync1;

    assign flags = {ri | ti, tf1, ie1, tf0, ie0};
    assign pend  = ie[7] ? (flags & ie[4:0]) : '0;
    assign hi_ok = isr_hi ? '0 : (pend & ip);
    assign lo_ok = (isr_hi | isr_lo) ? '0 : (pend & ~ip);

    // Scan from lowest priority upward so the last hit wins; high level overrides low
    always_comb begin
        win_any = 1'b0;
        win_src = SRC_IE0;
        win_hi  = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (lo_ok[i]) begin
                win_any = 1'b1;
                win_src = src_e'(3'(i));
                win_hi  = 1'b0;
            end
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (hi_ok[i]) begin
                win_any = 1'b1;
                win_src = src_e'(3'(i));
                win_hi  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        irq_nx     = irq;
        vector_nx  = vector;
        cur_src_nx = cur_src;
        cur_hi_nx  = cur_hi;
        clr_tf0_nx = 1'b0;
        clr_tf1_nx = 1'b0;
        set_hi     = 1'b0;
        set_lo     = 1'b0;
        drop_hi    = 1'b0;
        drop_lo    = 1'b0;
        clr_ie0    = 1'b0;
        clr_ie1    = 1'b0;
        reti_ok    = reti & (isr_hi | isr_lo);
        case (state)
            ST_IDLE, ST_HOLD: begin
                if (reti_ok) begin
                    drop_hi  = isr_hi;
                    drop_lo  = ~isr_hi;
                    irq_nx   = 1'b0;
                    state_nx = ST_HOLD;
                end else if (state == ST_HOLD) begin
                    state_nx = ST_IDLE;
                end else if (win_any) begin
                    irq_nx     = 1'b1;
                    vector_nx  = src_vector(win_src);
                    cur_src_nx = win_src;
                    cur_hi_nx  = win_hi;
                    state_nx   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (reti_ok) begin
                    drop_hi  = isr_hi;
                    drop_lo  = ~isr_hi;
                    irq_nx   = 1'b0;
                    state_nx = ST_HOLD;
                end else if (ack) begin
                    irq_nx     = 1'b0;
                    clr_tf0_nx = (cur_src == SRC_TF0);
                    clr_tf1_nx = (cur_src == SRC_TF1);
                    state_nx   = ST_VECT;
                end else if (win_any) begin
                    vector_nx  = src_vector(win_src);
                    cur_src_nx = win_src;
                    cur_hi_nx  = win_hi;
                end else begin
                    irq_nx   = 1'b0;
                    state_nx = ST_IDLE;
                end
            end
            ST_VECT: begin
                set_hi   = cur_hi;
                set_lo   = ~cur_hi;
                clr_ie0  = (cur_src == SRC_IE0);
                clr_ie1  = (cur_src == SRC_IE1);
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            irq     <= 1'b0;
            vector  <= 16'h0000;
            cur_src <= SRC_IE0;
            cur_hi  <= 1'b0;
            clr_tf0 <= 1'b0;
            clr_tf1 <= 1'b0;
            isr_hi  <= 1'b0;
            isr_lo  <= 1'b0;
        end else begin
            irq     <= irq_nx;
            vector  <= vector_nx;
            cur_src <= cur_src_nx;
            cur_hi  <= cur_hi_nx;
            clr_tf0 <= clr_tf0_nx;
            clr_tf1 <= clr_tf1_nx;
            isr_hi  <= (isr_hi & ~drop_hi) | set_hi;
            isr_lo  <= (isr_lo & ~drop_lo) | set_lo;
        end
    end

    // A fresh edge arriving in the service cycle wins over the clear
    always_ff @(posedge CLK) begin
        if (!reset || !it0) flag0 <= 1'b0;
        else if (fall0)     flag0 <= 1'b1;
        else if (clr_ie0)   flag0 <= 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!reset || !it1) flag1 <= 1'b0;
        else if (fall1)     flag1 <= 1'b1;
        else if (clr_ie1)   flag1 <= 1'b0;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-low reset (reset=0 at a CLK edge resets).
REQ-003 SHALL have port ie  in  8  IE register: bit7 EA, bit4 ES, bit3 ET1, bit2 EX1, bit1 ET0, bit0 EX0.
REQ-004 SHALL have port ip  in  5  IP register: bit4 PS, bit3 PT1, bit2 PX1, bit1 PT0, bit0 PX0; 1 = high level.
REQ-005 SHALL have ports int0_n, int1_n  in  1 each  asynchronous external interrupt pins, active low.
REQ-006 SHALL have ports it0, it1  in  1 each  TCON trigger select: 1 = falling edge, 0 = low level.
REQ-007 SHALL have ports tf0, tf1, ri, ti  in  1 each  timer overflow and serial flags.
REQ-008 SHALL have port ack  in  1  CPU accepts the request at an instruction boundary; one-cycle pulse.
REQ-009 SHALL have port reti  in  1  CPU executed RETI; one-cycle pulse.
REQ-010 SHALL have port irq  out  1  interrupt request to the CPU.
REQ-011 SHALL have port vector  out  16  LCALL target for the current request.
REQ-012 SHALL have ports ie0, ie1  out  1 each  TCON external interrupt flags.
REQ-013 SHALL have ports clr_tf0, clr_tf1  out  1 each  one-cycle clear pulses to the timer block.

Function
REQ-014 SHALL pass each int pin through a 2-flop synchronizer and a falling-edge detector; in edge mode ie0/ie1 set 3 CLK edges after the pin falls.
REQ-015 SHALL, in level mode, drive ie0/ie1 equal to the inverted synchronized pin, with no latching.
REQ-016 SHALL treat a source as pending when its flag is set, its enable bit is set, and EA=1; the serial flag is ri OR ti.
REQ-017 SHALL order sources within a level as IE0 > TF0 > IE1 > TF1 > serial, with vectors 0x0003, 0x000B, 0x0013, 0x001B, 0x0023.
REQ-018 SHALL let a pending high-level source beat any pending low-level source.
REQ-019 SHALL keep in-service bits isr_hi and isr_lo; a request is eligible only if its level is above all active in-service levels (high preempts low; nothing preempts high; same level never preempts).
REQ-020 SHALL implement FSM IDLE, REQ, VECT, HOLD.
REQ-021 SHALL move IDLE->REQ when an eligible source exists; irq and vector are registered, so irq rises one cycle after eligibility.
REQ-022 SHALL, in REQ, re-evaluate the winner every cycle, updating vector; if no eligible source remains before ack, drop irq and return to IDLE.
REQ-023 SHALL, on ack in REQ, commit the current vector and go to VECT; irq deasserts on the same edge.
REQ-024 SHALL, in VECT (one cycle), set the in-service bit of the committed level; pulse clr_tf0/clr_tf1 for timer sources; clear ie0/ie1 only for edge-mode sources; never clear ri/ti; then go to IDLE.
REQ-025 SHALL, on reti, clear isr_hi if set, else isr_lo; ignore reti when neither bit is set; go to HOLD.
REQ-026 SHALL stay in HOLD exactly one cycle with irq=0, then go to IDLE, so at least one instruction executes after RETI.
REQ-027 SHALL ignore ack outside REQ.
REQ-028 SHALL let reti take precedence over a new request in the same cycle.
REQ-029 SHALL keep vector stable from commit until the next REQ entry.

Reset
REQ-030 SHALL, on reset=0: set state IDLE; set irq, vector, ie0, ie1, clr_tf0, clr_tf1, isr_hi and isr_lo to 0; preset synchronizer flops to 1.
REQ-031 SHALL abandon any in-progress request on reset asserted mid-REQ/VECT without emitting clear pulses.

Structure
REQ-032 SHALL take vector constants, the source index encoding and the FSM state encoding from shared package mcu51_pkg.
REQ-033 SHALL use sub-module int_sync_edge (synchronizer plus edge detector), instantiated for INT0 and INT1.

Verification
REQ-034 SHALL cover: ie=0x81, ip=0, it0=1, int0_n falls -> ie0=1 after 3 edges, irq next cycle, vector=0x0003; ack -> ie0=0, isr_lo=1.
REQ-035 SHALL cover: ie=0x8A, ip=0x08, tf0 and tf1 set together -> vector=0x001B (high wins); ack -> clr_tf1 pulse, isr_hi=1.
REQ-036 SHALL cover: in low ISR (isr_lo=1), tf1 high-level pending -> irq with 0x001B; with only a low source pending -> irq stays 0.
REQ-037 SHALL cover: irq for TF1 low, then IE0 low pending before ack -> vector switches to 0x0003; ack commits 0x0003.
REQ-038 SHALL cover: reti with isr_hi=isr_lo=1 -> isr_hi=0, isr_lo=1, irq held 0 for the HOLD cycle.
REQ-039 SHALL cover: reset=0 during REQ -> next cycle irq=0, vector=0x0000, no clr pulse.
